// File: rtl/head_flit_queue_decoder.sv
// Head-flit store and route decoder for one router input port / VC plane.
// Phits are assembled into whole head flits, queued, and the oldest flit is decoded into a route request.
module head_flit_queue_decoder #(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int HFBDepth      = 4,
  parameter int REQUEST_WIDTH = 2,
  localparam int DEST_W       = (N > 1) ? $clog2(N) : 1,
  localparam int FLIT_W       = DATA_WIDTH * PhitPerFlit
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic                     full,
  output logic                     empty,
  output logic [FLIT_W-1:0]        dout,
  input  logic                     decodeHeadFlit,
  output logic [REQUEST_WIDTH-1:0] RequestMessage,
  output logic                     headFlitDecoded
);

  localparam int PTR_W = $clog2(HFBDepth);
  localparam int CNT_W = $clog2(HFBDepth + 1);
  localparam int PH_W  = (PhitPerFlit > 1) ? $clog2(PhitPerFlit) : 1;

  logic [FLIT_W-1:0] mem [HFBDepth];
  logic [FLIT_W-1:0] asm_q;
  logic [FLIT_W-1:0] flit_in;
  logic [PH_W-1:0]   phit_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              push_ok;
  logic              flit_done;
  logic              pop;
  logic [DEST_W-1:0] dest;

  // Handshake: a phit is taken when wr_en & ~full, a flit is released when rd_en & ~empty;
  // both qualifiers are sampled at the same rising edge, so a full queue refuses a write even while popping.
  assign push_ok   = wr_en & ~full;
  assign flit_done = push_ok & (phit_cnt == PH_W'(PhitPerFlit - 1));
  assign pop       = rd_en & ~empty;

  // The incoming phit lands in its slot of the assembly image; the last slot completes the flit.
  always_comb begin
    flit_in = asm_q;
    flit_in[int'(phit_cnt)*DATA_WIDTH +: DATA_WIDTH] = din;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (flit_done && !pop)      cnt_nxt = cnt + 1'b1;
    else if (!flit_done && pop) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)   asm_q       <= flit_in;
    if (flit_done) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phit_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok) phit_cnt <= flit_done ? '0 : phit_cnt + 1'b1;
      if (flit_done) wr_ptr <= (wr_ptr == PTR_W'(HFBDepth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)       rd_ptr <= (rd_ptr == PTR_W'(HFBDepth - 1)) ? '0 : rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CNT_W'(HFBDepth));
      empty <= (cnt_nxt == '0);
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

  // Route code: 0 local, 1 toward higher node numbers, 2 toward lower ones.
  assign dest            = dout[DEST_W-1:0];
  assign headFlitDecoded = decodeHeadFlit & ~empty;

  always_comb begin
    RequestMessage = '0;
    if (headFlitDecoded) begin
      if (dest == DEST_W'(INDEX))     RequestMessage = REQUEST_WIDTH'(0);
      else if (dest > DEST_W'(INDEX)) RequestMessage = REQUEST_WIDTH'(1);
      else                            RequestMessage = REQUEST_WIDTH'(2);
    end
  end

endmodule

// File: tb/tb_head_flit_queue_decoder.sv
// Directed bench for head_flit_queue_decoder: reset, assembly, decode, full/empty limits,
// simultaneous push/pop, pointer wrap and asynchronous reset of a partial flit.
module tb_head_flit_queue_decoder;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  din;
  logic        rd_en;
  logic        full;
  logic        empty;
  logic [15:0] dout;
  logic        decode;
  logic [1:0]  req;
  logic        decoded;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  head_flit_queue_decoder #(
    .N(4), .INDEX(1), .DATA_WIDTH(8), .PhitPerFlit(2), .HFBDepth(4), .REQUEST_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .full(full), .empty(empty), .dout(dout),
    .decodeHeadFlit(decode), .RequestMessage(req), .headFlitDecoded(decoded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_phit(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_flit(input logic [7:0] lo, input logic [7:0] hi);
    push_phit(lo);
    push_phit(hi);
    exp_q.push_back({hi, lo});
  endtask

  task automatic pop_raw();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    check(tag, dout, e);
    pop_raw();
  endtask

  task automatic decode_check(input string tag, input logic [1:0] code);
    decode = 1'b1;
    #1;
    check({tag, "_valid"}, decoded, 1'b1);
    check({tag, "_code"}, req, code);
    decode = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 1; wr_en = 0; din = 0; rd_en = 0; decode = 0;

    // 1. asynchronous reset with no clock edge
    #2 rst = 0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_dout", dout, 16'h0000);
    check("rst_req", req, 2'd0);
    check("rst_decoded", decoded, 1'b0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // 2. assemble one flit and decode it
    push_phit(8'h03);
    check("partial_empty", empty, 1'b1);
    push_phit(8'hAB);
    exp_q.push_back(16'hAB03);
    check("asm_empty", empty, 1'b0);
    check("asm_dout", dout, 16'hAB03);
    decode_check("dec_up", 2'd1);
    pop_check("asm_pop");
    check("asm_drained", empty, 1'b1);
    decode = 1'b1; #1;
    check("dec_empty_valid", decoded, 1'b0);
    check("dec_empty_code", req, 2'd0);
    decode = 1'b0;

    // 3. local, downward, upward routes
    push_flit(8'h01, 8'h10);
    push_flit(8'h00, 8'h20);
    push_flit(8'h02, 8'h30);
    decode_check("dec_local", 2'd0);
    pop_check("route_pop0");
    decode_check("dec_down", 2'd2);
    pop_check("route_pop1");
    decode_check("dec_up2", 2'd1);
    pop_check("route_pop2");
    check("route_empty", empty, 1'b1);

    // 4. fill, overflow attempts, full-with-pop refusal, drain, underflow
    for (int i = 0; i < 4; i++) push_flit(8'(8'h40 + i), 8'(8'hC0 + i));
    check("fill_full", full, 1'b1);
    check("fill_empty", empty, 1'b0);
    push_phit(8'hEE);
    push_phit(8'hEF);
    check("ovf_full", full, 1'b1);
    check("ovf_dout", dout, 16'hC040);
    wr_en = 1'b1; din = 8'h77; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    void'(exp_q.pop_front());
    check("fullpop_full", full, 1'b0);
    check("fullpop_dout", dout, 16'hC141);
    push_flit(8'h88, 8'h99);
    check("refill_full", full, 1'b1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain_%0d", i));
    check("drain_empty", empty, 1'b1);
    check("drain_full", full, 1'b0);
    pop_raw();
    check("udf_empty", empty, 1'b1);
    check("udf_dout", dout, 16'h0000);

    // 4b. completing a flit while empty: the pop is ignored, the write proceeds
    push_phit(8'h5A);
    wr_en = 1'b1; din = 8'hA5; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    exp_q.push_back(16'hA55A);
    check("emptypush_empty", empty, 1'b0);
    pop_check("emptypush_pop");

    // 5. simultaneous completion and pop keep the count
    push_flit(8'h61, 8'h71);
    push_flit(8'h62, 8'h72);
    push_phit(8'h63);
    wr_en = 1'b1; din = 8'h73; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(16'h7363);
    check("simul_full", full, 1'b0);
    check("simul_dout", dout, 16'h7262);
    pop_check("simul_pop0");
    pop_check("simul_pop1");
    check("simul_empty", empty, 1'b1);

    // 5b. stream 10 flits through to wrap both pointers
    for (int i = 0; i < 10; i++) begin
      push_flit(8'($urandom_range(0, 255)), 8'(8'h90 + i));
      if (exp_q.size() >= 3) pop_check($sformatf("stream_%0d", i));
    end
    while (exp_q.size() > 0) pop_check("stream_drain");
    check("stream_empty", empty, 1'b1);

    // 6. asynchronous reset discards a partial flit
    push_phit(8'h55);
    #2 rst = 0;
    #1;
    check("arst_empty", empty, 1'b1);
    check("arst_dout", dout, 16'h0000);
    #1 rst = 1;
    @(posedge clk); #1;
    push_phit(8'h11);
    push_phit(8'h22);
    check("post_rst_dout", dout, 16'h2211);
    decode_check("post_rst_local", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
